// File: rtl/irq_sense_unit_if.sv
// Signal bundle between the IRQ sense unit and the interrupt controller / bench.
// The master drives the pins, configuration and acknowledges. The slave returns status and requests.
interface irq_sense_unit_if #(
    parameter int N_IRQ = 16,
    parameter int ID_W  = 5
);
    logic [N_IRQ-1:0]   irq_pin;
    logic [2*N_IRQ-1:0] sense_cfg;
    logic [N_IRQ-1:0]   ier;
    logic [N_IRQ-1:0]   dtc_sel;
    logic               isr_wr_en;
    logic [N_IRQ-1:0]   isr_wdata;
    logic               cpu_ack;
    logic               dtc_ack;
    logic [ID_W-1:0]    ack_id;
    logic [N_IRQ-1:0]   isr_rdata;
    logic [N_IRQ-1:0]   irq_req;
    logic [N_IRQ-1:0]   dtc_req;
    logic               irq_valid;
    logic [ID_W-1:0]    irq_id;

    modport master (
        output irq_pin, sense_cfg, ier, dtc_sel, isr_wr_en, isr_wdata,
               cpu_ack, dtc_ack, ack_id,
        input  isr_rdata, irq_req, dtc_req, irq_valid, irq_id
    );

    modport slave (
        input  irq_pin, sense_cfg, ier, dtc_sel, isr_wr_en, isr_wdata,
               cpu_ack, dtc_ack, ack_id,
        output isr_rdata, irq_req, dtc_req, irq_valid, irq_id
    );
endinterface

// File: rtl/irq_sense_unit.sv
// External IRQ input stage: per-pin synchroniser, glitch filter, sense detection,
// write-0-to-clear status, and CPU/DTC request routing with a registered priority encoder.
module irq_sense_unit #(
    parameter int N_IRQ       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 2,
    parameter int ID_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    irq_sense_unit_if.slave bus
);
    localparam int CNT_W = $clog2(FILT_CYCLES + 1);
    localparam int FL_W  = $clog2(SYNC_STAGES + 1);

    logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_filtCnt [N_IRQ];
    logic [N_IRQ-1:0] r_filt;
    logic [N_IRQ-1:0] r_filtD;
    logic [N_IRQ-1:0] r_armed;
    logic [N_IRQ-1:0] r_status;
    logic [FL_W-1:0]  r_flushCnt;
    logic             r_irqValid;
    logic [ID_W-1:0]  r_irqId;

    logic [N_IRQ-1:0] w_sync;
    logic             w_flushed;
    logic [N_IRQ-1:0] w_edgeEv;
    logic [N_IRQ-1:0] w_levelEv;
    logic [N_IRQ-1:0] w_clear;
    logic [N_IRQ-1:0] w_req;
    logic             w_anyReq;
    logic [ID_W-1:0]  w_lowId;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '1;
            end
        end else begin
            r_sync[0] <= bus.irq_pin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // The chain holds reset ones for SYNC_STAGES cycles after release. This counter marks
    // when the last stage first carries a real pin sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flushCnt <= '0;
        end else if (!w_flushed) begin
            r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign w_flushed = (r_flushCnt == FL_W'(SYNC_STAGES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= '1;
            for (int i = 0; i < N_IRQ; i++) begin
                r_filtCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_filtCnt[i] <= '0;
                end else if (r_filtCnt[i] == CNT_W'(FILT_CYCLES)) begin
                    r_filt[i]    <= w_sync[i];
                    r_filtCnt[i] <= '0;
                end else begin
                    r_filtCnt[i] <= r_filtCnt[i] + 1'b1;
                end
            end
        end
    end

    // Edges count only once a channel has been seen idle-high after reset. A pin held low
    // through reset therefore shows up as a level and never as a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filtD <= '1;
            r_armed <= '0;
        end else begin
            r_filtD <= r_filt;
            r_armed <= r_armed | ({N_IRQ{w_flushed}} & w_sync);
        end
    end

    always_comb begin
        w_edgeEv  = '0;
        w_levelEv = '0;
        w_clear   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            case (bus.sense_cfg[2*i +: 2])
                2'b00:   w_levelEv[i] = ~r_filt[i];
                2'b01:   w_edgeEv[i]  = r_armed[i] & r_filtD[i] & ~r_filt[i];
                2'b10:   w_edgeEv[i]  = r_armed[i] & ~r_filtD[i] & r_filt[i];
                default: w_edgeEv[i]  = r_armed[i] & (r_filtD[i] ^ r_filt[i]);
            endcase
            w_clear[i] = (bus.isr_wr_en & ~bus.isr_wdata[i])
                       | (bus.cpu_ack & ~bus.dtc_sel[i] & (bus.ack_id == ID_W'(i)))
                       | (bus.dtc_ack &  bus.dtc_sel[i] & (bus.ack_id == ID_W'(i)));
        end
    end

    // Edge events win over a same-cycle clear so none is lost. A held low level yields to the
    // clear for that one cycle and re-asserts on the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            r_status <= w_edgeEv | (~w_clear & (r_status | w_levelEv));
        end
    end

    assign w_req = r_status & bus.ier & ~bus.dtc_sel;

    always_comb begin
        w_anyReq = |w_req;
        w_lowId  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_lowId = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irqValid <= 1'b0;
            r_irqId    <= '0;
        end else begin
            r_irqValid <= w_anyReq;
            if (w_anyReq) begin
                r_irqId <= w_lowId;
            end
        end
    end

    assign bus.isr_rdata = r_status;
    assign bus.irq_req   = w_req;
    assign bus.dtc_req   = r_status & bus.ier & bus.dtc_sel;
    assign bus.irq_valid = r_irqValid;
    assign bus.irq_id    = r_irqId;
endmodule
